// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared word width, enable levels, div_op encodings and FSM states
package div_unit_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W = 5;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
// Ports: i_rem partial remainder (WIDTH+1), i_dvs divisor magnitude, i_bit next dividend bit,
//        o_rem new partial remainder, o_q quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_dvs,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);
  logic [WIDTH+1:0] w_diff;
  // One extra bit beyond the shifted remainder gives a clean borrow flag.
  assign w_diff = {i_rem, i_bit} - {2'b00, i_dvs};
  assign o_q = ~w_diff[WIDTH+1];
  assign o_rem = o_q ? w_diff[WIDTH:0] : {i_rem[WIDTH-1:0], i_bit};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative signed/unsigned divider (DIV, DIVU, REM, REMU), one quotient bit per cycle
// Ports: clk, rst_n (async active-low); request div_valid/div_ready/div_op/div_dividend/div_divisor;
//        div_flush aborts; result res_valid/res_ready/res_data; busy high in CALC or DONE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_dvs, r_res;
  logic             r_valid, r_is_rem, r_neg_q, r_neg_r;
  logic             w_signed, w_is_rem, w_a_neg, w_b_neg, w_zero, w_ovf, w_q;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_fin, w_r_fin, w_res;
  logic [WIDTH:0]   w_rem;
  assign w_signed = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
  assign w_is_rem = (div_op == DIV_OP_REM) || (div_op == DIV_OP_REMU);
  assign w_a_neg = w_signed & div_dividend[WIDTH-1];
  assign w_b_neg = w_signed & div_divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? -div_dividend : div_dividend;
  assign w_b_mag = w_b_neg ? -div_divisor : div_divisor;
  assign w_zero = div_divisor == '0;
  assign w_ovf = w_signed && div_dividend == {1'b1, {(WIDTH-1){1'b0}}} && &div_divisor;
  // r_quo shifts the dividend out of its MSB while quotient bits shift in at the LSB.
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_dvs (r_dvs),
    .i_bit (r_quo[WIDTH-1]),
    .o_rem (w_rem),
    .o_q   (w_q)
  );
  assign w_q_fin = {r_quo[WIDTH-2:0], w_q};
  assign w_r_fin = w_rem[WIDTH-1:0];
  assign w_res = r_is_rem ? (r_neg_r ? -w_r_fin : w_r_fin) : (r_neg_q ? -w_q_fin : w_q_fin);
  assign div_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign res_valid = r_valid;
  assign res_data = r_res;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_res <= '0;
      r_valid <= DISABLE;
      r_is_rem <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (div_flush) begin
      r_state <= IDLE;
      r_valid <= DISABLE;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (div_valid) begin
          r_is_rem <= w_is_rem;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt <= '0;
          if (w_zero || w_ovf) begin
            r_state <= DONE;
            r_valid <= ENABLE;
            r_res <= w_zero ? (w_is_rem ? div_dividend : '1) : (w_is_rem ? '0 : div_dividend);
          end else begin
            r_state <= CALC;
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
          end
        end
        CALC: begin
          r_rem <= w_rem;
          r_quo <= w_q_fin;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_res <= w_res;
            r_valid <= ENABLE;
            r_state <= DONE;
          end
        end
        DONE: if (res_ready) begin
          r_valid <= DISABLE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed self-checking bench for div_unit against an arithmetic model
module tb_div_unit;
  import div_unit_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_valid = 1'b0, div_flush = 1'b0, res_ready = 1'b0;
  logic        div_ready, res_valid, busy;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] div_dividend = '0, div_divisor = '0, res_data;
  int          n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_op       (div_op),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_flush    (div_flush),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 0) return (op == DIV_OP_REM || op == DIV_OP_REMU) ? a : 32'hFFFF_FFFF;
    case (op)
      DIV_OP_DIV:  return 32'(sa / sb);
      DIV_OP_REM:  return 32'(sa % sb);
      DIV_OP_DIVU: return 32'(ua / ub);
      default:     return 32'(ua % ub);
    endcase
  endfunction
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_d, held;
    int exp_l, n;
    exp_d = model(op, a, b);
    exp_l = (b == 0 || ((op == DIV_OP_DIV || op == DIV_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    @(negedge clk);
    check("ready_before", 32'(div_ready), 32'd1);
    div_op = op;
    div_dividend = a;
    div_divisor = b;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("latency op=%0d a=%08h b=%08h", op, a, b), 32'(n), 32'(exp_l));
    check($sformatf("data op=%0d a=%08h b=%08h", op, a, b), res_data, exp_d);
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_data", res_data, held);
      check("hold_ready", 32'(div_ready), 32'd0);
      check("hold_valid", 32'(res_valid), 32'd1);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("ready_after", 32'(div_ready), 32'd1);
    check("valid_after", 32'(res_valid), 32'd0);
    check("idle_data", res_data, held);
  endtask
  initial begin
    int rises;
    logic [1:0] op;
    logic [31:0] a, b;
    #1;
    check("rst_ready", 32'(div_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", res_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(DIV_OP_DIVU, 32'd100, 32'd7, 5);
    run(DIV_OP_REMU, 32'd100, 32'd7, 0);
    run(DIV_OP_DIV, -32'sd7, 32'd2, 0);
    run(DIV_OP_REM, -32'sd7, 32'd2, 0);
    run(DIV_OP_DIV, 32'd7, -32'sd2, 0);
    run(DIV_OP_DIVU, 32'h1234_5678, 32'd0, 0);
    run(DIV_OP_REMU, 32'h1234_5678, 32'd0, 0);
    run(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("req_div_neg", model(DIV_OP_DIV, -32'sd7, 32'd2), 32'hFFFF_FFFD);
    @(negedge clk);
    div_op = DIV_OP_DIVU;
    div_dividend = 32'hFFFF_FFFF;
    div_divisor = 32'd3;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_flush = 1'b0;
    check("flush_ready", 32'(div_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    rises = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid) rises++;
    end
    check("flush_no_result", 32'(rises), 32'd0);
    run(DIV_OP_DIVU, 32'd9, 32'd3, 0);
    @(negedge clk);
    div_valid = 1'b1;
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    div_flush = 1'b0;
    check("flush_beats_valid", 32'(div_ready), 32'd1);
    @(negedge clk);
    div_op = DIV_OP_DIVU;
    div_dividend = 32'd1000;
    div_divisor = 32'd9;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(res_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(div_ready), 32'd1);
    check("rst_mid_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(1, 20)) - 32'd10; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run(op, a, b, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width; all data ports SHALL use the shared WORD_DATA range.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port div_valid, input, 1, request valid.
REQ-005 The block SHALL have port div_ready, output, 1, able to accept a request.
REQ-006 The block SHALL have port div_op, input, 2, the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 The block SHALL have port div_dividend, input, WIDTH, operand rs1.
REQ-008 The block SHALL have port div_divisor, input, WIDTH, operand rs2.
REQ-009 The block SHALL have port div_flush, input, 1, abort any in-flight operation.
REQ-010 The block SHALL have port res_valid, output, 1, result valid.
REQ-011 The block SHALL have port res_ready, input, 1, consumer accepts the result.
REQ-012 The block SHALL have port res_data, output, WIDTH, the quotient or remainder.
REQ-013 The block SHALL have port busy, output, 1, high in CALC or DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE; div_ready SHALL be high only in IDLE.
REQ-015 A request SHALL be accepted on a cycle T where div_valid=1, div_ready=1 and div_flush=0; operands and op are latched at T.
REQ-016 If the divisor is 0, the block SHALL go IDLE->DONE with res_valid=1 at T+1. The quotient SHALL be all ones and the remainder SHALL be the dividend.
REQ-017 For signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF), the block SHALL go IDLE->DONE at T+1 with quotient 0x80000000 and remainder 0.
REQ-018 Otherwise the block SHALL go IDLE->CALC. For signed ops it SHALL use operand magnitudes. It SHALL perform radix-2 restoring division, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, counted by a 5-bit counter from 0 to 31.
REQ-019 On the last CALC cycle the block SHALL register the sign-corrected result and enter DONE, so that res_valid=1 at T+33.
REQ-020 The quotient SHALL be negated when the operand signs differ for DIV. The remainder SHALL take the sign of the dividend for REM.
REQ-021 The internal partial remainder SHALL be WIDTH+1 bits wide; the trial subtract SHALL NOT overflow.
REQ-022 In DONE, res_valid=1 and res_data SHALL stay stable until res_ready=1. The block SHALL then go DONE->IDLE, with div_ready high the next cycle; there is no same-cycle re-accept.
REQ-023 div_flush=1 in any state SHALL force IDLE on the next edge, with res_valid=0 and no result delivered. If div_flush and div_valid are high together, flush SHALL win and the request SHALL not be accepted.
REQ-024 In IDLE, res_data SHALL hold its last delivered value; in CALC, res_valid SHALL be 0.

Reset
REQ-025 When rst_n=0, all registers SHALL clear immediately regardless of clk. State SHALL be IDLE, res_valid=0, res_data=0, busy=0 and the counter 0.
REQ-026 During reset, div_ready SHALL be 1 (IDLE); reset mid-CALC or mid-DONE SHALL discard the operation.

Structure
REQ-027 WORD_DATA, ENABLE/DISABLE and the div_op encodings (DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU) SHALL live in the shared global include; there SHALL be no local literals for op codes.
REQ-028 One sub-module, div_step, SHALL be used: combinational, one restoring iteration. Inputs are the partial remainder, divisor and next dividend bit; outputs are the new partial remainder and the quotient bit. All sequencing SHALL stay in div_unit.

Verification
REQ-029 The bench SHALL cover DIVU 100/7: res_data=14 at T+33; REMU 100/7: res_data=2.
REQ-030 The bench SHALL cover DIV -7/2: res_data=0xFFFFFFFD; REM -7/2: res_data=0xFFFFFFFF; DIV 7/-2: res_data=0xFFFFFFFD.
REQ-031 The bench SHALL cover DIVU 0x12345678/0: res_data=0xFFFFFFFF at T+1; REMU of the same operands: res_data=0x12345678 at T+1.
REQ-032 The bench SHALL cover DIV 0x80000000/0xFFFFFFFF: res_data=0x80000000 at T+1; REM of the same operands: res_data=0.
REQ-033 The bench SHALL cover flush on CALC cycle 10: res_valid never rises and div_ready=1 the next cycle. A following DIVU 9/3 SHALL then return 3 at T+33.
REQ-034 The bench SHALL cover backpressure and reset. Holding res_ready=0 for 5 cycles in DONE SHALL keep res_data stable and div_ready=0. Dropping rst_n mid-CALC SHALL immediately give res_valid=0, busy=0 and div_ready=1.
